// File: rtl/dp_ram_fifo_ctrl_if.sv
// rtl/dp_ram_fifo_ctrl_if.sv - stream, status and dual-port RAM signals of the FIFO controller
// slave is the controller's view; master is the environment (source, sink, RAM).
interface dp_ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     s_valid;
    logic [DATA_WIDTH-1:0]    s_data;
    logic                     s_ready;
    logic                     m_valid;
    logic [DATA_WIDTH-1:0]    m_data;
    logic                     m_ready;
    logic [ADDRESS_WIDTH+1:0] count;
    logic                     ram_en;
    logic                     ram_wr1;
    logic                     ram_wr2;
    logic [ADDRESS_WIDTH-1:0] ram_add_1;
    logic [ADDRESS_WIDTH-1:0] ram_add_2;
    logic [DATA_WIDTH-1:0]    ram_data_1;
    logic [DATA_WIDTH-1:0]    ram_data_2;
    logic [DATA_WIDTH-1:0]    ram_out_2;

    modport slave (
        input  s_valid, s_data, m_ready, ram_out_2,
        output s_ready, m_valid, m_data, count,
               ram_en, ram_wr1, ram_wr2, ram_add_1, ram_add_2, ram_data_1, ram_data_2
    );

    modport master (
        output s_valid, s_data, m_ready, ram_out_2,
        input  s_ready, m_valid, m_data, count,
               ram_en, ram_wr1, ram_wr2, ram_add_1, ram_add_2, ram_data_1, ram_data_2
    );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// rtl/dp_ram_fifo_ctrl.sv - FIFO controller over an external synchronous dual-port RAM
// Port 1 writes, port 2 reads; a two-entry head/skid buffer hides the one-cycle RAM read latency.
module dp_ram_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    dp_ram_fifo_ctrl_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CW    = ADDRESS_WIDTH + 1;
    localparam int NW    = ADDRESS_WIDTH + 2;

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            mem_count_q, mem_count_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [1:0]               out_cnt_q, out_cnt_d;
    logic [DATA_WIDTH-1:0]    head_q, head_d;
    logic [DATA_WIDTH-1:0]    skid_q, skid_d;

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] out_after_pop;
    logic [2:0] buffered_after_pop;

    assign bus.s_ready = rst_n && (mem_count_q < CW'(DEPTH));
    assign bus.m_valid = (out_cnt_q != 2'd0);
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = bus.m_valid && bus.m_ready;

    // Issue only while the buffer plus the in-flight read leaves a free slot after this pop.
    assign out_after_pop      = 3'(out_cnt_q) - 3'(pop);
    assign buffered_after_pop = out_after_pop + 3'(rd_pend_q);
    assign issue              = (mem_count_q != '0) && (buffered_after_pop < 3'd2);

    always_comb begin
        wr_ptr_d    = push  ? wr_ptr_q + ADDRESS_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d    = issue ? rd_ptr_q + ADDRESS_WIDTH'(1) : rd_ptr_q;
        rd_pend_d   = issue;
        mem_count_d = mem_count_q;
        if (push && !issue) begin
            mem_count_d = mem_count_q + CW'(1);
        end else if (!push && issue) begin
            mem_count_d = mem_count_q - CW'(1);
        end

        head_d    = head_q;
        skid_d    = skid_q;
        out_cnt_d = buffered_after_pop[1:0];
        if (pop) begin
            head_d = skid_q;
        end
        // RAM data lands in whichever slot is the tail once this cycle's pop is applied.
        if (rd_pend_q) begin
            if (out_after_pop == 3'd0) begin
                head_d = bus.ram_out_2;
            end else begin
                skid_d = bus.ram_out_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            rd_pend_q   <= 1'b0;
            out_cnt_q   <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            rd_pend_q   <= rd_pend_d;
            out_cnt_q   <= out_cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
        end
    end

    assign bus.m_data     = head_q;
    assign bus.count      = NW'(mem_count_q) + NW'(rd_pend_q) + NW'(out_cnt_q);
    assign bus.ram_en     = rst_n;
    assign bus.ram_wr1    = push;
    assign bus.ram_add_1  = wr_ptr_q;
    assign bus.ram_data_1 = push ? bus.s_data : '0;
    assign bus.ram_wr2    = 1'b0;
    assign bus.ram_add_2  = rd_ptr_q;
    assign bus.ram_data_2 = '0;
endmodule
